bit_serializer: RTL
===================

Name: bit_serializer

Overview:
Parallel-to-serial front end feeding the serial sequence-detector stage: accepts WIDTH-bit words over a valid/ready handshake and drives one bit per enabled clock onto a single serial line.
Holds a one-word buffer behind the shift register, so back-to-back words stream with no idle bit between them.
The output bit ser_x connects directly to the detector's serial input x.

Parameters:
WIDTH, 8, word width in bits (>=2)
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first; 0 = bit 0 first

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  asynchronous, active-high reset
in_data  input  WIDTH  word to serialize
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a word this cycle
shift_en  input  1  advance enable; low = hold the current bit
ser_x  output  1  serial data bit (to detector x)
ser_valid  output  1  ser_x carries a real data bit
word_done  output  1  one-cycle pulse: last bit of a word is on ser_x
busy  output  1  shifter active or buffer occupied

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst). All flops clear immediately on rst rising, regardless of clk.
- Reset values: ser_x=0, ser_valid=0, word_done=0, busy=0, in_ready=0 while rst is high, 1 on the first cycle after release. Buffer is empty, state is IDLE, bit counter is 0.
- Storage:
  - WIDTH-bit shift register, sh.
  - Bit counter, cnt, of $clog2(WIDTH) bits.
  - One-entry buffer, buf, with flag buf_full.
- Handshake:
  - in_ready = !buf_full (registered flag, not combinational on in_valid).
  - A transfer occurs on an edge where in_valid && in_ready.
  - in_data is sampled only on a transfer edge.
- States: IDLE, SHIFT.
- IDLE:
  - ser_valid=0 and ser_x=0.
  - On a transfer edge: the word bypasses buf and loads sh directly, cnt=0, next state SHIFT.
  - Latency: first bit on ser_x in the cycle after the transfer edge.
- SHIFT, general rules:
  - ser_valid=1.
  - ser_x = sh[WIDTH-1] if MSB_FIRST, else sh[0].
  - When shift_en=0, sh, cnt and ser_x hold.
- SHIFT, advancing (shift_en=1, cnt<WIDTH-1): sh shifts toward the output end, cnt increments.
- SHIFT, last bit (shift_en=1, cnt==WIDTH-1), word_done=1 this cycle:
  - buf_full: load sh from buf, clear buf_full, cnt=0, stay in SHIFT. No gap bit.
  - buf empty and a transfer on the same edge: load sh from in_data directly, cnt=0, stay in SHIFT.
  - Otherwise: go to IDLE.
- Word accepted during SHIFT without the last-bit load condition: the word goes into buf and buf_full=1.
- Simultaneous transfer and buf→sh move cannot occur, because in_ready=0 while buf_full.
- word_done is combinational: (state==SHIFT && cnt==WIDTH-1 && shift_en). It is not asserted while stalled on the last bit.
- busy = (state==SHIFT) || buf_full.
- Reset mid-word: the partial word and the buffered word are discarded. Outputs return to reset values asynchronously, and no word_done is issued.
- shift_en is ignored in IDLE. A load from IDLE happens even when shift_en=0, but the first bit then holds until shift_en=1.

Test Plan:
- Reset release, MSB_FIRST=1: in_data=8'hD5, single transfer, shift_en=1 → ser_x=1,1,0,1,0,1,0,1 on 8 consecutive cycles starting one cycle after the transfer. ser_valid high for exactly 8 cycles; word_done on the 8th; then IDLE, ser_x=0.
- Back-to-back: 8'hB3 then 8'h0F held valid → 16 contiguous valid bits 10110011 00001111. in_ready drops to 0 once buf fills and returns to 1 on the edge where buf moves to sh. Two word_done pulses 8 cycles apart.
- Stall: shift_en low for 3 cycles after the 3rd bit of 8'hAA → ser_x holds 1 for 3 extra cycles, the sequence resumes 0,1,0,1,0, and word_done is delayed by 3 cycles.
- LSB-first build (MSB_FIRST=0), in_data=8'h01 → ser_x=1,0,0,0,0,0,0,0.
- Async reset: assert rst mid-clock during the 4th bit with buf full → outputs clear before the next clk edge, busy=0, no word_done. After release the next word streams cleanly.
- End-to-end with the detector: serialize 8'hAA, 8'hAA → the detector's z pattern matches its stand-alone bench driven with the same 16 bits.

Source files
------------

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end with a one-word skid buffer.
// Words arrive on a valid/ready handshake and leave one bit per enabled clock
// on ser_x. A word arriving while the shifter is busy waits in the buffer, so
// back-to-back words stream with no idle bit between them.
module bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             shift_en,
  output logic             ser_x,
  output logic             ser_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] buf_data;
  logic             buf_full;
  logic             buf_full_n;
  logic             ready_q;
  logic             xfer;
  logic             last_adv;

  assign xfer     = in_valid && ready_q;
  assign last_adv = (state == SHIFT) && shift_en && (cnt == LAST);

  assign in_ready  = ready_q;
  assign ser_valid = (state == SHIFT);
  assign ser_x     = (state == SHIFT) ? (MSB_FIRST ? sh[WIDTH-1] : sh[0]) : 1'b0;
  assign word_done = last_adv;
  assign busy      = (state == SHIFT) || buf_full;

  // Next buffer occupancy: drained on the last bit, filled by a transfer that
  // cannot go straight into the shifter.
  always_comb begin
    buf_full_n = buf_full;
    if (last_adv && buf_full)
      buf_full_n = 1'b0;
    else if (xfer && (state == SHIFT) && !last_adv)
      buf_full_n = 1'b1;
  end

  // Shifter FSM, buffer and registered ready flag.
  // in_ready is kept as its own flop (tracking !buf_full) so that it reads 0
  // throughout reset and rises on the first edge after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sh       <= '0;
      cnt      <= '0;
      buf_data <= '0;
      buf_full <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      buf_full <= buf_full_n;
      ready_q  <= !buf_full_n;
      case (state)
        IDLE: begin
          if (xfer) begin
            sh    <= in_data;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (cnt == LAST) begin
              if (buf_full) begin
                sh  <= buf_data;
                cnt <= '0;
              end else if (xfer) begin
                sh  <= in_data;
                cnt <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              sh  <= MSB_FIRST ? {sh[WIDTH-2:0], 1'b0} : {1'b0, sh[WIDTH-1:1]};
              cnt <= cnt + CW'(1);
            end
          end
          if (xfer && !last_adv)
            buf_data <= in_data;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
